modulo_controlador_transferencia_rolhas: RTL and testbench
==========================================================

MODULO_CONTROLADOR_TRANSFERENCIA_ROLHAS -- requirements
Module: modulo_controlador_transferencia_rolhas

Interface
REQ-001 The block SHALL have these parameters:
- MIN_ROLHAS, default 5: primary-buffer refill threshold.
- LOTE, default 15: maximum corks per transfer batch.
- MAX_ROLHAS, default 99: capacity of each buffer.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single system clock (divided clock); all state updates on its rising edge.
- clr, in, 1: asynchronous, active-high reset.
- en, in, 1: machine running (start_stop); enables transfer starts.
- veda, in, 1: cork consumed by the sealing stage this cycle.
- op_load, in, 1: operator load strobe, one-cycle pulse.
- op_qtd, in, 7: corks the operator adds to the secondary buffer.
- rolhas_principal, out, 7: primary buffer count (registered).
- rolhas_secundario, out, 7: secondary buffer count (registered).
- transf_ativa, out, 1: high while in TRANSF.
- ro, out, 1: primary empty; combinational, high when rolhas_principal==0.
- load_ack, out, 1: one-cycle pulse; operator load applied.
- load_err, out, 1: one-cycle pulse; operator load rejected.
- estado, out, 2: FSM state code.

Function
REQ-003 The FSM SHALL have three states, encoded on estado:
- IDLE=00
- TRANSF=01
- CARGA=10
- Code 11 is illegal and SHALL return to IDLE on the next edge.

REQ-004 In any state, veda=1 with rolhas_principal>0 SHALL decrement rolhas_principal by 1 on that edge.

REQ-005 veda=1 with rolhas_principal==0 SHALL be ignored; counts are unchanged and ro stays 1.

REQ-006 In IDLE, a pending load (REQ-011) SHALL take priority: the FSM SHALL go to CARGA.

REQ-007 Otherwise, in IDLE with en=1, rolhas_principal<MIN_ROLHAS and rolhas_secundario>0, the FSM SHALL go to TRANSF. It SHALL load the batch counter with min(LOTE, rolhas_secundario, MAX_ROLHAS-rolhas_principal).

REQ-008 Each cycle in TRANSF SHALL:
- increment rolhas_principal by 1;
- decrement rolhas_secundario by 1;
- decrement the batch counter by 1.
If veda=1 in the same cycle, the net change to rolhas_principal SHALL be 0.

REQ-009 TRANSF SHALL return to IDLE on the edge where the batch counter reaches 0.

REQ-010 If en falls during TRANSF, the current-cycle move SHALL complete, the remaining batch SHALL be discarded, and the FSM SHALL return to IDLE on the same edge.

REQ-011 An op_load pulse SHALL capture op_qtd into a one-deep pending register in any state.

REQ-012 An op_load arriving while a load is already pending SHALL be dropped, with a load_err pulse on the next cycle.

REQ-013 CARGA SHALL last one cycle and then return to IDLE. Using a 9-bit internal sum:
- If rolhas_secundario+pending ≤ MAX_ROLHAS: rolhas_secundario += pending, and load_ack pulses on the next cycle.
- Otherwise: no change, and load_err pulses on the next cycle.
- In both cases the pending register SHALL be cleared.

REQ-014 A pending value of 0 SHALL be acknowledged with load_ack and leave the counts unchanged.

REQ-015 An op_load arriving in IDLE SHALL be served via CARGA on the following edge, giving an op_load-to-load_ack latency of 2 cycles.

REQ-016 Neither count SHALL ever exceed MAX_ROLHAS or wrap below 0; all arithmetic SHALL be unsigned 7-bit with explicit guards.

REQ-017 load_ack and load_err SHALL never be asserted in the same cycle.

Reset
REQ-018 On clr=1, regardless of clk, the block SHALL immediately set:
- estado=IDLE;
- both counts=0;
- batch counter=0;
- pending cleared;
- transf_ativa=0, load_ack=0, load_err=0.
ro SHALL therefore be 1.

REQ-019 clr asserted during TRANSF or CARGA SHALL abort the operation with no partial update after release.

REQ-020 The first state change after clr deasserts SHALL occur on the next rising clk edge.

Verification
REQ-021 Load: from reset, op_load with op_qtd=40 -> load_ack two cycles later, then:
- rolhas_secundario=40;
- with en=1, a TRANSF of 15 cycles follows;
- end state principal=15, secundario=25, estado=IDLE.

REQ-022 Clamped batch: principal=2, secundario=7, en=1 -> TRANSF of exactly 7 cycles; end state principal=9, secundario=0.

REQ-023 Capacity clamp: principal=4 (set up via consume), secundario=99, MIN_ROLHAS raised to 99 -> batch=95; principal ends at 99 with no wrap.

REQ-024 Overflow reject: secundario=90, op_load op_qtd=20 -> load_err pulse, secundario stays 90.

REQ-025 Pending load during TRANSF:
- op_load (10) during TRANSF is held and served after TRANSF ends, with load_ack.
- A second op_load while pending -> load_err; only 10 added.

REQ-026 veda during TRANSF holds principal constant while secundario still decrements. Reset asserted mid-TRANSF -> all counts 0, estado=00, ro=1 immediately.

Source files
------------

// File: rtl/modulo_controlador_transferencia_rolhas.sv
// Cork transfer controller: moves corks from the secondary to the primary buffer
// in bounded batches and serves one-deep buffered operator loads into the secondary buffer.
module modulo_controlador_transferencia_rolhas #(
  parameter int MIN_ROLHAS = 5,
  parameter int LOTE       = 15,
  parameter int MAX_ROLHAS = 99
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       veda,
  input  logic       op_load,
  input  logic [6:0] op_qtd,
  output logic [6:0] rolhas_principal,
  output logic [6:0] rolhas_secundario,
  output logic       transf_ativa,
  output logic       ro,
  output logic       load_ack,
  output logic       load_err,
  output logic [1:0] estado
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    TRANSF = 2'b01,
    CARGA  = 2'b10
  } estado_t;

  localparam logic [6:0] MIN_C  = 7'(MIN_ROLHAS);
  localparam logic [6:0] LOTE_C = 7'(LOTE);
  localparam logic [6:0] MAX_C  = 7'(MAX_ROLHAS);

  estado_t    estado_q, estado_d;
  logic [6:0] prin_q, prin_d;
  logic [6:0] sec_q, sec_d;
  logic [6:0] lote_q, lote_d;
  logic [6:0] pend_q, pend_d;
  logic       pend_vld_q, pend_vld_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;

  logic [6:0] cap;
  logic [6:0] lote_ini;
  logic [8:0] soma;
  logic       mover;
  logic       consumir;
  logic       pend_ocupado;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      estado_q   <= IDLE;
      prin_q     <= '0;
      sec_q      <= '0;
      lote_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      prin_q     <= prin_d;
      sec_q      <= sec_d;
      lote_q     <= lote_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    sec_d      = sec_q;
    lote_d     = lote_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;

    // Batch size is the tightest of: batch limit, corks available, room in primary.
    cap      = (prin_q < MAX_C) ? (MAX_C - prin_q) : 7'd0;
    lote_ini = LOTE_C;
    if (sec_q < lote_ini) lote_ini = sec_q;
    if (cap < lote_ini)   lote_ini = cap;

    soma = {2'b00, sec_q} + {2'b00, pend_q};

    // A cork moved in the same cycle as a seal is consumed on arrival, so the net is 0.
    mover    = (estado_q == TRANSF) && (lote_q != 7'd0) && (sec_q != 7'd0) && (prin_q < MAX_C);
    consumir = veda && ((prin_q != 7'd0) || mover);
    prin_d   = prin_q + {6'b0, mover} - {6'b0, consumir};

    case (estado_q)
      IDLE: begin
        if (pend_vld_q || op_load) begin
          estado_d = CARGA;
        end else if (en && (prin_q < MIN_C) && (sec_q != 7'd0) && (lote_ini != 7'd0)) begin
          estado_d = TRANSF;
          lote_d   = lote_ini;
        end
      end
      TRANSF: begin
        if (mover) begin
          sec_d  = sec_q - 7'd1;
          lote_d = lote_q - 7'd1;
        end
        if (!en || (lote_q <= 7'd1) || !mover) begin
          estado_d = IDLE;
          lote_d   = 7'd0;
        end
      end
      CARGA: begin
        if (soma <= 9'(MAX_ROLHAS)) begin
          sec_d = soma[6:0];
          ack_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        pend_vld_d = 1'b0;
        pend_d     = 7'd0;
        estado_d   = IDLE;
      end
      default: estado_d = IDLE;
    endcase

    // The slot being drained in CARGA is free again, so a load landing there is accepted.
    pend_ocupado = pend_vld_q && (estado_q != CARGA);
    if (op_load) begin
      if (pend_ocupado) begin
        err_d = 1'b1;
      end else begin
        pend_d     = op_qtd;
        pend_vld_d = 1'b1;
      end
    end
  end

  assign rolhas_principal  = prin_q;
  assign rolhas_secundario = sec_q;
  assign transf_ativa      = (estado_q == TRANSF);
  assign ro                = (prin_q == 7'd0);
  assign load_ack          = ack_q;
  assign load_err          = err_q;
  assign estado            = estado_q;

endmodule

// File: tb/tb_modulo_controlador_transferencia_rolhas.sv
// Directed bench for the cork transfer controller; a second instance with raised
// threshold and batch limit exercises the primary-capacity clamp.
module tb_modulo_controlador_transferencia_rolhas;

  logic       clk, clr, en, veda, op_load;
  logic [6:0] op_qtd;
  logic [6:0] prin, sec, p2, s2;
  logic       transf, ro, ack, err, t2, ro2, ack2, err2;
  logic [1:0] est, est2;
  int         n_cmp = 0;
  int         n_err = 0;

  modulo_controlador_transferencia_rolhas dut (
    .clk(clk), .clr(clr), .en(en), .veda(veda), .op_load(op_load), .op_qtd(op_qtd),
    .rolhas_principal(prin), .rolhas_secundario(sec), .transf_ativa(transf), .ro(ro),
    .load_ack(ack), .load_err(err), .estado(est)
  );

  modulo_controlador_transferencia_rolhas #(.MIN_ROLHAS(99), .LOTE(99), .MAX_ROLHAS(99)) dut2 (
    .clk(clk), .clr(clr), .en(en), .veda(veda), .op_load(op_load), .op_qtd(op_qtd),
    .rolhas_principal(p2), .rolhas_secundario(s2), .transf_ativa(t2), .ro(ro2),
    .load_ack(ack2), .load_err(err2), .estado(est2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1; en = 1'b0; veda = 1'b0; op_load = 1'b0; op_qtd = 7'd0;
    tick();
    tick();
    clr = 1'b0;
  endtask

  // Drives a one-cycle load from IDLE and returns at the cycle where the response is visible.
  task automatic load(input logic [6:0] q);
    op_load = 1'b1; op_qtd = q;
    tick();
    op_load = 1'b0; op_qtd = 7'd0;
    tick();
  endtask

  task automatic wait_transf(input bit sel, output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (sel ? t2 : transf) n++;
      else if (n > 0) break;
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; en = 1'b0; veda = 1'b0; op_load = 1'b0; op_qtd = 7'd0;
    tick();
    tick();
    n_cmp++; if (prin !== 7'd0) begin n_err++; $display("FAIL rst_prin: got %0d want 0", prin); end
    n_cmp++; if (sec !== 7'd0) begin n_err++; $display("FAIL rst_sec: got %0d want 0", sec); end
    n_cmp++; if (est !== 2'b00) begin n_err++; $display("FAIL rst_estado: got %0d want 0", est); end
    n_cmp++; if ({ro, transf, ack, err} !== 4'b1000) begin n_err++; $display("FAIL rst_flags: got %b want 1000", {ro, transf, ack, err}); end
    clr = 1'b0;
  endtask

  task automatic test_veda_empty();
    veda = 1'b1;
    tick();
    veda = 1'b0;
    n_cmp++; if (prin !== 7'd0 || ro !== 1'b1) begin n_err++; $display("FAIL veda_empty: got prin=%0d ro=%0d want prin=0 ro=1", prin, ro); end
  endtask

  task automatic test_load_transfer();
    int n;
    do_reset();
    op_load = 1'b1; op_qtd = 7'd40;
    tick();
    op_load = 1'b0; op_qtd = 7'd0;
    n_cmp++; if (est !== 2'b10 || ack !== 1'b0) begin n_err++; $display("FAIL load_carga: got estado=%0d ack=%0d want estado=2 ack=0", est, ack); end
    tick();
    n_cmp++; if (ack !== 1'b1 || err !== 1'b0) begin n_err++; $display("FAIL load_ack: got ack=%0d err=%0d want ack=1 err=0", ack, err); end
    n_cmp++; if (sec !== 7'd40) begin n_err++; $display("FAIL load_sec: got %0d want 40", sec); end
    en = 1'b1;
    wait_transf(1'b0, n);
    n_cmp++; if (n !== 15) begin n_err++; $display("FAIL lote15_cycles: got %0d want 15", n); end
    n_cmp++; if (prin !== 7'd15 || sec !== 7'd25 || est !== 2'b00) begin n_err++; $display("FAIL lote15_end: got prin=%0d sec=%0d estado=%0d want 15 25 0", prin, sec, est); end
    en = 1'b0;
  endtask

  task automatic test_clamped();
    int n;
    do_reset();
    load(7'd2);
    en = 1'b1;
    wait_transf(1'b0, n);
    n_cmp++; if (n !== 2 || prin !== 7'd2) begin n_err++; $display("FAIL clamp_setup: got n=%0d prin=%0d want 2 2", n, prin); end
    load(7'd7);
    n_cmp++; if (ack !== 1'b1 || sec !== 7'd7) begin n_err++; $display("FAIL clamp_load: got ack=%0d sec=%0d want 1 7", ack, sec); end
    wait_transf(1'b0, n);
    n_cmp++; if (n !== 7) begin n_err++; $display("FAIL clamp_cycles: got %0d want 7", n); end
    n_cmp++; if (prin !== 7'd9 || sec !== 7'd0) begin n_err++; $display("FAIL clamp_end: got prin=%0d sec=%0d want 9 0", prin, sec); end
    en = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    load(7'd90);
    n_cmp++; if (sec !== 7'd90) begin n_err++; $display("FAIL ovf_setup: got %0d want 90", sec); end
    load(7'd20);
    n_cmp++; if (err !== 1'b1 || ack !== 1'b0) begin n_err++; $display("FAIL ovf_err: got err=%0d ack=%0d want 1 0", err, ack); end
    n_cmp++; if (sec !== 7'd90) begin n_err++; $display("FAIL ovf_sec: got %0d want 90", sec); end
    tick();
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL ovf_pulse: got err=%0d want 0", err); end
    load(7'd0);
    n_cmp++; if (ack !== 1'b1 || err !== 1'b0 || sec !== 7'd90) begin n_err++; $display("FAIL zero_load: got ack=%0d err=%0d sec=%0d want 1 0 90", ack, err, sec); end
    load(7'd9);
    n_cmp++; if (ack !== 1'b1 || sec !== 7'd99) begin n_err++; $display("FAIL full_load: got ack=%0d sec=%0d want 1 99", ack, sec); end
  endtask

  task automatic test_pending();
    bit got;
    do_reset();
    load(7'd40);
    en = 1'b1;
    tick();
    tick();
    n_cmp++; if (transf !== 1'b1) begin n_err++; $display("FAIL pend_in_transf: got transf=%0d want 1", transf); end
    op_load = 1'b1; op_qtd = 7'd10;
    tick();
    op_qtd = 7'd3;
    tick();
    op_load = 1'b0; op_qtd = 7'd0;
    n_cmp++; if (err !== 1'b1 || ack !== 1'b0) begin n_err++; $display("FAIL pend_drop: got err=%0d ack=%0d want 1 0", err, ack); end
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    n_cmp++; if (got !== 1'b1 || err !== 1'b0) begin n_err++; $display("FAIL pend_served: got ack_seen=%0d err=%0d want 1 0", got, err); end
    n_cmp++; if (sec !== 7'd35 || prin !== 7'd15) begin n_err++; $display("FAIL pend_counts: got prin=%0d sec=%0d want 15 35", prin, sec); end
    en = 1'b0;
  endtask

  task automatic test_en_drop();
    logic [6:0] p, s;
    do_reset();
    load(7'd40);
    en = 1'b1;
    tick();
    tick();
    tick();
    p = prin; s = sec;
    en = 1'b0;
    tick();
    n_cmp++; if (prin !== p + 7'd1 || sec !== s - 7'd1 || est !== 2'b00) begin n_err++; $display("FAIL en_drop: got prin=%0d sec=%0d estado=%0d want %0d %0d 0", prin, sec, est, p + 7'd1, s - 7'd1); end
    tick();
    n_cmp++; if (prin !== p + 7'd1 || est !== 2'b00) begin n_err++; $display("FAIL en_drop_hold: got prin=%0d estado=%0d want %0d 0", prin, est, p + 7'd1); end
  endtask

  task automatic test_veda_transf_reset();
    logic [6:0] p, s;
    do_reset();
    load(7'd40);
    en = 1'b1;
    tick();
    tick();
    p = prin; s = sec;
    veda = 1'b1;
    tick();
    veda = 1'b0;
    n_cmp++; if (prin !== p || sec !== s - 7'd1 || est !== 2'b01) begin n_err++; $display("FAIL veda_transf: got prin=%0d sec=%0d estado=%0d want %0d %0d 1", prin, sec, est, p, s - 7'd1); end
    #3 clr = 1'b1;
    #1;
    n_cmp++; if (prin !== 7'd0 || sec !== 7'd0 || est !== 2'b00 || ro !== 1'b1 || transf !== 1'b0) begin n_err++; $display("FAIL async_clr: got prin=%0d sec=%0d estado=%0d ro=%0d transf=%0d want 0 0 0 1 0", prin, sec, est, ro, transf); end
    tick();
    clr = 1'b0;
    tick();
    tick();
    n_cmp++; if (prin !== 7'd0 || sec !== 7'd0 || est !== 2'b00) begin n_err++; $display("FAIL post_clr: got prin=%0d sec=%0d estado=%0d want 0 0 0", prin, sec, est); end
    en = 1'b0;
  endtask

  task automatic test_capacity();
    int n;
    do_reset();
    load(7'd10);
    en = 1'b1;
    wait_transf(1'b1, n);
    en = 1'b0;
    n_cmp++; if (n !== 10 || p2 !== 7'd10) begin n_err++; $display("FAIL cap_setup: got n=%0d prin=%0d want 10 10", n, p2); end
    veda = 1'b1;
    repeat (6) tick();
    veda = 1'b0;
    n_cmp++; if (p2 !== 7'd4) begin n_err++; $display("FAIL cap_consume: got %0d want 4", p2); end
    load(7'd99);
    n_cmp++; if (ack2 !== 1'b1 || err2 !== 1'b0 || s2 !== 7'd99) begin n_err++; $display("FAIL cap_load: got ack=%0d err=%0d sec=%0d want 1 0 99", ack2, err2, s2); end
    en = 1'b1;
    wait_transf(1'b1, n);
    n_cmp++; if (n !== 95) begin n_err++; $display("FAIL cap_batch: got %0d want 95", n); end
    n_cmp++; if (p2 !== 7'd99 || s2 !== 7'd4) begin n_err++; $display("FAIL cap_end: got prin=%0d sec=%0d want 99 4", p2, s2); end
    repeat (3) tick();
    n_cmp++; if (p2 !== 7'd99 || est2 !== 2'b00 || ro2 !== 1'b0) begin n_err++; $display("FAIL cap_hold: got prin=%0d estado=%0d ro=%0d want 99 0 0", p2, est2, ro2); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_veda_empty();
    test_load_transfer();
    test_clamped();
    test_overflow();
    test_pending();
    test_en_drop();
    test_veda_transf_reset();
    test_capacity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
